// File: rtl/zynqparrot_mem_arbiter_if.sv
// Bundle of request, downstream-memory and routed-response signals around the memory-port arbiter.
// Names carry the arbiter's point of view: _i enters the arbiter, _o leaves it.
interface zynqparrot_mem_arbiter_if #(
  parameter int num_req_p     = 2,
  parameter int data_width_p  = 64,
  parameter int paddr_width_p = 34,
  parameter int len_width_p   = 4
);
  logic [num_req_p-1:0]               req_v_i;
  logic [num_req_p-1:0]               req_ready_and_o;
  logic [num_req_p-1:0]               req_wr_i;
  logic [num_req_p*paddr_width_p-1:0] req_addr_i;
  logic [num_req_p*len_width_p-1:0]   req_len_i;
  logic [num_req_p*data_width_p-1:0]  req_data_i;
  logic [num_req_p-1:0]               req_last_i;

  logic                     mem_req_v_o;
  logic                     mem_req_ready_and_i;
  logic                     mem_req_wr_o;
  logic [paddr_width_p-1:0] mem_req_addr_o;
  logic [len_width_p-1:0]   mem_req_len_o;
  logic [data_width_p-1:0]  mem_req_data_o;
  logic                     mem_req_last_o;

  logic                    mem_resp_v_i;
  logic                    mem_resp_ready_and_o;
  logic [data_width_p-1:0] mem_resp_data_i;
  logic                    mem_resp_last_i;

  logic [num_req_p-1:0]    resp_v_o;
  logic [num_req_p-1:0]    resp_ready_and_i;
  logic [data_width_p-1:0] resp_data_o;
  logic                    resp_last_o;

  modport slave (
    input  req_v_i, req_wr_i, req_addr_i, req_len_i, req_data_i, req_last_i,
    output req_ready_and_o,
    output mem_req_v_o, mem_req_wr_o, mem_req_addr_o, mem_req_len_o, mem_req_data_o, mem_req_last_o,
    input  mem_req_ready_and_i,
    input  mem_resp_v_i, mem_resp_data_i, mem_resp_last_i,
    output mem_resp_ready_and_o,
    output resp_v_o, resp_data_o, resp_last_o,
    input  resp_ready_and_i
  );

  modport master (
    output req_v_i, req_wr_i, req_addr_i, req_len_i, req_data_i, req_last_i,
    input  req_ready_and_o,
    input  mem_req_v_o, mem_req_wr_o, mem_req_addr_o, mem_req_len_o, mem_req_data_o, mem_req_last_o,
    output mem_req_ready_and_i,
    output mem_resp_v_i, mem_resp_data_i, mem_resp_last_i,
    input  mem_resp_ready_and_o,
    input  resp_v_o, resp_data_o, resp_last_o,
    output resp_ready_and_i
  );
endinterface

// File: rtl/zynqparrot_mem_arbiter.sv
// Round-robin arbiter locking the shared memory port for whole messages; a grant-order FIFO
// (tag_els_p >= 2, power of 2) steers the in-order responses back to their requesters.
module zynqparrot_mem_arbiter #(
  parameter int num_req_p     = 2,
  parameter int data_width_p  = 64,
  parameter int paddr_width_p = 34,
  parameter int len_width_p   = 4,
  parameter int tag_els_p     = 4
) (
  input  logic aclk,
  input  logic aresetn,
  zynqparrot_mem_arbiter_if.slave bus
);

  localparam int id_w  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_w = $clog2(tag_els_p);
  localparam int cnt_w = $clog2(tag_els_p) + 1;

  typedef enum logic {e_idle, e_stream} state_e;

  state_e              state_q, state_d;
  logic [id_w-1:0]     grant_q, grant_d;
  logic                hold_v_q, hold_v_d;
  logic [id_w-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ptr_w-1:0]    wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]    cnt_q;
  logic [id_w-1:0]     tag_mem_q [tag_els_p];

  logic                rr_found;
  logic [id_w-1:0]     rr_pick;
  logic [id_w-1:0]     cur_grant;
  logic                cur_v;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [id_w-1:0]     head;
  logic                resp_rdy;

  function automatic logic [id_w-1:0] next_id(input logic [id_w-1:0] id);
    if (id == id_w'(num_req_p - 1)) return '0;
    return id + 1'b1;
  endfunction

  assign fifo_full  = (cnt_q == cnt_w'(tag_els_p));
  assign fifo_empty = (cnt_q == '0);
  assign head       = tag_mem_q[rd_ptr_q];

  // First valid requester scanning upward from rr_ptr, wrapping at num_req_p.
  always_comb begin
    int k;
    k        = 0;
    rr_found = 1'b0;
    rr_pick  = rr_ptr_q;
    for (int i = 0; i < num_req_p; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= num_req_p) k = k - num_req_p;
      if (!rr_found && bus.req_v_i[k]) begin
        rr_found = 1'b1;
        rr_pick  = id_w'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hold_v_d  = hold_v_q;
    rr_ptr_d  = rr_ptr_q;
    cur_grant = grant_q;
    cur_v     = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      e_idle: begin
        // A stalled first beat keeps its grant so the payload cannot switch under the stall.
        cur_grant = hold_v_q ? grant_q : rr_pick;
        cur_v     = !fifo_full && bus.req_v_i[cur_grant];
        if (cur_v) begin
          if (bus.mem_req_ready_and_i) begin
            push     = 1'b1;
            hold_v_d = 1'b0;
            if (bus.req_last_i[cur_grant]) begin
              rr_ptr_d = next_id(cur_grant);
            end else begin
              state_d = e_stream;
              grant_d = cur_grant;
            end
          end else begin
            hold_v_d = 1'b1;
            grant_d  = cur_grant;
          end
        end else begin
          hold_v_d = 1'b0;
        end
      end
      e_stream: begin
        cur_v = bus.req_v_i[grant_q];
        if (cur_v && bus.mem_req_ready_and_i && bus.req_last_i[grant_q]) begin
          state_d  = e_idle;
          rr_ptr_d = next_id(grant_q);
        end
      end
      default: begin
        state_d = e_idle;
      end
    endcase
  end

  assign resp_rdy = aresetn && !fifo_empty && bus.resp_ready_and_i[head];
  assign pop      = bus.mem_resp_v_i && resp_rdy && bus.mem_resp_last_i;

  // Every output is forced low while aresetn is asserted, independent of the clock.
  always_comb begin
    bus.req_ready_and_o = '0;
    bus.mem_req_v_o     = 1'b0;
    bus.mem_req_wr_o    = 1'b0;
    bus.mem_req_addr_o  = '0;
    bus.mem_req_len_o   = '0;
    bus.mem_req_data_o  = '0;
    bus.mem_req_last_o  = 1'b0;
    bus.resp_v_o        = '0;
    bus.resp_data_o     = '0;
    bus.resp_last_o     = 1'b0;
    bus.mem_resp_ready_and_o = resp_rdy;
    if (aresetn) begin
      bus.mem_req_v_o    = cur_v;
      if (cur_v) bus.req_ready_and_o[cur_grant] = bus.mem_req_ready_and_i;
      bus.mem_req_wr_o   = bus.req_wr_i[cur_grant];
      bus.mem_req_addr_o = bus.req_addr_i[int'(cur_grant)*paddr_width_p +: paddr_width_p];
      bus.mem_req_len_o  = bus.req_len_i[int'(cur_grant)*len_width_p +: len_width_p];
      bus.mem_req_data_o = bus.req_data_i[int'(cur_grant)*data_width_p +: data_width_p];
      bus.mem_req_last_o = bus.req_last_i[cur_grant];
      if (!fifo_empty) bus.resp_v_o[head] = bus.mem_resp_v_i;
      bus.resp_data_o    = bus.mem_resp_data_i;
      bus.resp_last_o    = bus.mem_resp_last_i;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= e_idle;
      grant_q  <= '0;
      hold_v_q <= 1'b0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < tag_els_p; i++) tag_mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
      if (push) begin
        tag_mem_q[wr_ptr_q] <= cur_grant;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_zynqparrot_mem_arbiter.sv
// Directed bench for the memory-port arbiter: read, contention with a full grant FIFO,
// locked write with backpressure, and reset in the middle of a stream.
module tb_zynqparrot_mem_arbiter;
  localparam int NR = 2;
  localparam int DW = 64;
  localparam int AW = 34;
  localparam int LW = 4;
  localparam int TE = 4;

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;

  zynqparrot_mem_arbiter_if #(
    .num_req_p(NR), .data_width_p(DW), .paddr_width_p(AW), .len_width_p(LW)
  ) bus ();

  zynqparrot_mem_arbiter #(
    .num_req_p(NR), .data_width_p(DW), .paddr_width_p(AW), .len_width_p(LW), .tag_els_p(TE)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic set_req(input int idx, input logic v, input logic wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len, input logic [DW-1:0] data, input logic last);
    bus.req_v_i[idx]              = v;
    bus.req_wr_i[idx]             = wr;
    bus.req_addr_i[idx*AW +: AW]  = addr;
    bus.req_len_i[idx*LW +: LW]   = len;
    bus.req_data_i[idx*DW +: DW]  = data;
    bus.req_last_i[idx]           = last;
  endtask

  task automatic set_resp(input logic v, input logic [DW-1:0] data, input logic last);
    bus.mem_resp_v_i    = v;
    bus.mem_resp_data_i = data;
    bus.mem_resp_last_i = last;
  endtask

  task automatic clear_all();
    bus.req_v_i    = '0;
    bus.req_wr_i   = '0;
    bus.req_addr_i = '0;
    bus.req_len_i  = '0;
    bus.req_data_i = '0;
    bus.req_last_i = '0;
    bus.mem_req_ready_and_i = 1'b1;
    set_resp(1'b0, '0, 1'b0);
    bus.resp_ready_and_i = '1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_all();
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    aresetn = 1'b0;
    clear_all();

    // Reset state with active inputs: everything must stay low.
    set_req(0, 1'b1, 1'b0, 34'h1234, 4'd0, 64'hDEAD, 1'b1);
    set_req(1, 1'b1, 1'b0, 34'h5678, 4'd0, 64'hBEEF, 1'b1);
    set_resp(1'b1, 64'h77, 1'b1);
    mid();
    chk_eq("rst_mem_req_v",  64'(bus.mem_req_v_o), 64'd0);
    chk_eq("rst_req_ready",  64'(bus.req_ready_and_o), 64'd0);
    chk_eq("rst_mem_addr",   64'(bus.mem_req_addr_o), 64'd0);
    chk_eq("rst_mem_last",   64'(bus.mem_req_last_o), 64'd0);
    chk_eq("rst_resp_rdy",   64'(bus.mem_resp_ready_and_o), 64'd0);
    chk_eq("rst_resp_v",     64'(bus.resp_v_o), 64'd0);
    chk_eq("rst_resp_data",  64'(bus.resp_data_o), 64'd0);
    do_reset();

    // Single read, len=1 -> two response beats.
    set_req(0, 1'b1, 1'b0, 34'h0_8000_0000, 4'd1, 64'd0, 1'b1);
    mid();
    chk_eq("rd_v",    64'(bus.mem_req_v_o), 64'd1);
    chk_eq("rd_rdy",  64'(bus.req_ready_and_o), 64'b01);
    chk_eq("rd_addr", 64'(bus.mem_req_addr_o), 64'h8000_0000);
    chk_eq("rd_len",  64'(bus.mem_req_len_o), 64'd1);
    chk_eq("rd_wr",   64'(bus.mem_req_wr_o), 64'd0);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_resp(1'b1, 64'hA, 1'b0);
    mid();
    chk_eq("rd_once",    64'(bus.mem_req_v_o), 64'd0);
    chk_eq("rd_b0_v",    64'(bus.resp_v_o), 64'b01);
    chk_eq("rd_b0_data", bus.resp_data_o, 64'hA);
    chk_eq("rd_b0_last", 64'(bus.resp_last_o), 64'd0);
    chk_eq("rd_b0_rdy",  64'(bus.mem_resp_ready_and_o), 64'd1);
    tick();
    set_resp(1'b1, 64'hB, 1'b1);
    mid();
    chk_eq("rd_b1_v",    64'(bus.resp_v_o), 64'b01);
    chk_eq("rd_b1_data", bus.resp_data_o, 64'hB);
    chk_eq("rd_b1_last", 64'(bus.resp_last_o), 64'd1);
    tick();
    mid();
    chk_eq("rd_empty_rdy", 64'(bus.mem_resp_ready_and_o), 64'd0);
    chk_eq("rd_empty_v",   64'(bus.resp_v_o), 64'd0);
    tick();

    // Contention from reset: grants alternate until the 4-deep FIFO fills.
    do_reset();
    set_req(0, 1'b1, 1'b0, 34'h100, 4'd0, 64'd0, 1'b1);
    set_req(1, 1'b1, 1'b0, 34'h200, 4'd0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      mid();
      chk_eq("ct_rdy",  64'(bus.req_ready_and_o), (i % 2 == 0) ? 64'b01 : 64'b10);
      chk_eq("ct_addr", 64'(bus.mem_req_addr_o), (i % 2 == 0) ? 64'h100 : 64'h200);
      tick();
    end
    mid();
    chk_eq("full_rdy", 64'(bus.req_ready_and_o), 64'b00);
    chk_eq("full_v",   64'(bus.mem_req_v_o), 64'd0);
    tick();
    set_resp(1'b1, 64'h11, 1'b1);
    mid();
    chk_eq("full_pop_rdy", 64'(bus.req_ready_and_o), 64'b00);
    chk_eq("full_rsp_v",   64'(bus.resp_v_o), 64'b01);
    tick();
    set_resp(1'b0, '0, 1'b0);
    mid();
    chk_eq("full_regrant", 64'(bus.req_ready_and_o), 64'b01);
    chk_eq("full_re_addr", 64'(bus.mem_req_addr_o), 64'h100);
    tick();
    bus.req_v_i = '0;
    for (int i = 0; i < 4; i++) begin
      set_resp(1'b1, 64'(i), 1'b1);
      mid();
      chk_eq("ct_route", 64'(bus.resp_v_o), (i % 2 == 0) ? 64'b10 : 64'b01);
      tick();
    end
    mid();
    chk_eq("ct_drained", 64'(bus.mem_resp_ready_and_o), 64'd0);
    tick();

    // Write lock, held idle grant, and downstream backpressure.
    do_reset();
    bus.mem_req_ready_and_i = 1'b0;
    set_req(1, 1'b1, 1'b1, 34'h300, 4'd3, 64'hD0, 1'b0);
    mid();
    chk_eq("wl_stall_rdy",  64'(bus.req_ready_and_o), 64'b00);
    chk_eq("wl_stall_v",    64'(bus.mem_req_v_o), 64'd1);
    chk_eq("wl_stall_addr", 64'(bus.mem_req_addr_o), 64'h300);
    tick();
    set_req(0, 1'b1, 1'b0, 34'h400, 4'd0, 64'd0, 1'b1);
    mid();
    chk_eq("wl_hold_addr", 64'(bus.mem_req_addr_o), 64'h300);
    tick();
    bus.mem_req_ready_and_i = 1'b1;
    mid();
    chk_eq("wl_b0_rdy",  64'(bus.req_ready_and_o), 64'b10);
    chk_eq("wl_b0_data", bus.mem_req_data_o, 64'hD0);
    chk_eq("wl_b0_wr",   64'(bus.mem_req_wr_o), 64'd1);
    chk_eq("wl_b0_len",  64'(bus.mem_req_len_o), 64'd3);
    tick();
    bus.req_data_i[1*DW +: DW] = 64'hD1;
    mid();
    chk_eq("wl_b1_rdy",  64'(bus.req_ready_and_o), 64'b10);
    chk_eq("wl_b1_data", bus.mem_req_data_o, 64'hD1);
    tick();
    bus.req_data_i[1*DW +: DW] = 64'hD2;
    bus.mem_req_ready_and_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk_eq("bp_rdy",  64'(bus.req_ready_and_o), 64'b00);
      chk_eq("bp_v",    64'(bus.mem_req_v_o), 64'd1);
      chk_eq("bp_data", bus.mem_req_data_o, 64'hD2);
      chk_eq("bp_addr", 64'(bus.mem_req_addr_o), 64'h300);
      tick();
    end
    bus.mem_req_ready_and_i = 1'b1;
    mid();
    chk_eq("wl_b2_rdy",  64'(bus.req_ready_and_o), 64'b10);
    chk_eq("wl_b2_data", bus.mem_req_data_o, 64'hD2);
    tick();
    bus.req_data_i[1*DW +: DW] = 64'hD3;
    bus.req_last_i[1] = 1'b1;
    mid();
    chk_eq("wl_b3_rdy",  64'(bus.req_ready_and_o), 64'b10);
    chk_eq("wl_b3_data", bus.mem_req_data_o, 64'hD3);
    chk_eq("wl_b3_last", 64'(bus.mem_req_last_o), 64'd1);
    tick();
    set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    mid();
    chk_eq("wl_next_rdy",  64'(bus.req_ready_and_o), 64'b01);
    chk_eq("wl_next_addr", 64'(bus.mem_req_addr_o), 64'h400);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_resp(1'b1, 64'h0, 1'b1);
    bus.resp_ready_and_i = 2'b01;
    mid();
    chk_eq("ack_v",     64'(bus.resp_v_o), 64'b10);
    chk_eq("ack_stall", 64'(bus.mem_resp_ready_and_o), 64'd0);
    tick();
    bus.resp_ready_and_i = 2'b11;
    mid();
    chk_eq("ack_go", 64'(bus.mem_resp_ready_and_o), 64'd1);
    tick();
    set_resp(1'b1, 64'h44, 1'b1);
    mid();
    chk_eq("wl_rd0_v", 64'(bus.resp_v_o), 64'b01);
    tick();
    set_resp(1'b0, '0, 1'b0);

    // Reset asserted on beat 2 of a 4-beat write from requester 1.
    do_reset();
    set_req(1, 1'b1, 1'b1, 34'h500, 4'd3, 64'hE0, 1'b0);
    tick();
    bus.req_data_i[1*DW +: DW] = 64'hE1;
    tick();
    bus.req_data_i[1*DW +: DW] = 64'hE2;
    #1 aresetn = 1'b0;
    #1;
    chk_eq("mr_v",    64'(bus.mem_req_v_o), 64'd0);
    chk_eq("mr_rdy",  64'(bus.req_ready_and_o), 64'b00);
    chk_eq("mr_data", bus.mem_req_data_o, 64'd0);
    chk_eq("mr_addr", 64'(bus.mem_req_addr_o), 64'd0);
    tick();
    clear_all();
    tick();
    aresetn = 1'b1;
    set_resp(1'b1, 64'h55, 1'b1);
    mid();
    chk_eq("mr_empty_rdy", 64'(bus.mem_resp_ready_and_o), 64'd0);
    chk_eq("mr_empty_v",   64'(bus.resp_v_o), 64'd0);
    tick();
    set_resp(1'b0, '0, 1'b0);
    set_req(0, 1'b1, 1'b0, 34'h600, 4'd0, 64'd0, 1'b1);
    set_req(1, 1'b1, 1'b0, 34'h700, 4'd0, 64'd0, 1'b1);
    mid();
    chk_eq("mr_first_rdy",  64'(bus.req_ready_and_o), 64'b01);
    chk_eq("mr_first_addr", 64'(bus.mem_req_addr_o), 64'h600);
    tick();
    clear_all();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
